// File: rtl/bitcoin_pkg.sv
// bitcoin_pkg
// Shared SHA-256 constants, types and helper functions for the nonce
// sweeper. Hash state is packed with element 0 holding working variable
// 'a' (or h0); the message window is packed with element 0 holding the
// oldest word, i.e. the one consumed by the current round.
package bitcoin_pkg;

    typedef logic [7:0][31:0]  hash_t;
    typedef logic [15:0][31:0] wbuf_t;

    typedef enum logic [3:0] {
        IDLE, READ, BLK1, FIN1, LD2, BLK2, FIN2, LD3, BLK3, FIN3, CHK, WR2, DONE
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Written high word first so that element 0 of the packed array is h0.
    localparam hash_t IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [31:0] PAD_WORD = 32'h8000_0000;
    localparam logic [31:0] LEN_BLK2 = 32'd640;
    localparam logic [31:0] LEN_BLK3 = 32'd256;
    localparam logic [31:0] NO_HIT   = 32'hffff_ffff;

    function automatic logic [31:0] rightrotate(input logic [31:0] x, input int unsigned r);
        return (x >> r) | (x << (32 - r));
    endfunction

    // One compression round: returns the next a..h for message word w and
    // round constant k.
    function automatic hash_t sha256_op(input hash_t s, input logic [31:0] w,
                                        input logic [31:0] k);
        logic [31:0] bigS0, bigS1, ch, maj, t1, t2;
        hash_t r;
        bigS1 = rightrotate(s[4], 6) ^ rightrotate(s[4], 11) ^ rightrotate(s[4], 25);
        ch    = (s[4] & s[5]) ^ (~s[4] & s[6]);
        t1    = s[7] + bigS1 + ch + k + w;
        bigS0 = rightrotate(s[0], 2) ^ rightrotate(s[0], 13) ^ rightrotate(s[0], 22);
        maj   = (s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]);
        t2    = bigS0 + maj;
        r[0] = t1 + t2;
        r[1] = s[0];
        r[2] = s[1];
        r[3] = s[2];
        r[4] = s[3] + t1;
        r[5] = s[4];
        r[6] = s[5];
        r[7] = s[6];
        return r;
    endfunction

    // Message word sixteen positions ahead of the oldest word in the window.
    function automatic logic [31:0] schedule_word(input wbuf_t w);
        logic [31:0] s0, s1;
        s0 = rightrotate(w[1], 7) ^ rightrotate(w[1], 18) ^ (w[1] >> 3);
        s1 = rightrotate(w[14], 17) ^ rightrotate(w[14], 19) ^ (w[14] >> 10);
        return s1 + w[9] + s0 + w[0];
    endfunction

endpackage

// File: rtl/bitcoin_miner_sha256_round.sv
// sha256_round
// Purely combinational single SHA-256 round plus one step of the rolling
// 16-word message schedule. Shared by all three compression passes.
// Ports:
//   hash_i  current working variables a..h (element 0 = a)
//   w_i     message window, element 0 is this round's word
//   t_i     round index, selects K[t]
//   hash_o  working variables after the round
//   w_o     window shifted by one with the new schedule word appended
module sha256_round
    import bitcoin_pkg::*;
(
    input  hash_t      hash_i,
    input  wbuf_t      w_i,
    input  logic [5:0] t_i,
    output hash_t      hash_o,
    output wbuf_t      w_o
);

    assign hash_o = sha256_op(hash_i, w_i[0], K[t_i]);
    assign w_o    = {schedule_word(w_i), w_i[15:1]};

endmodule

// File: rtl/bitcoin_miner.sv
// bitcoin_miner
// Double-SHA-256 nonce sweeper. Reads a 19-word header prefix, computes
// the first-block midstate once, then hashes every nonce of the requested
// range, either dumping h0 of each result or stopping at the first h0
// below the target.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start, mode               job request (IDLE only), 0 = dump, 1 = search
//   message_addr, output_addr header and result base addresses
//   nonce_start, nonce_count  nonce range
//   target                    search threshold on final h0
//   done, found, found_nonce  job status
//   mem_*                     word memory port, read data one cycle late
module bitcoin_miner
    import bitcoin_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic [31:0]       nonce_start,
    input  logic [CNT_W-1:0]  nonce_count,
    input  logic [31:0]       target,
    output logic              done,
    output logic              found,
    output logic [31:0]       found_nonce,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    state_t             state_q, state_d;
    hash_t              hash_q, hash_d;
    hash_t              mid_q, mid_d;
    wbuf_t              w_q, w_d;
    logic [2:0][31:0]   held_q, held_d;
    logic [5:0]         rnd_q, rnd_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        nonce_q, nonce_d;
    logic [31:0]        h0_q, h0_d;
    logic [31:0]        tgt_q, tgt_d;
    logic               mode_q, mode_d;
    logic [ADDR_W-1:0]  out_q, out_d;
    logic               done_q, done_d;
    logic               found_q, found_d;
    logic [31:0]        fnonce_q, fnonce_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    hash_t              rndHash;
    wbuf_t              rndW;
    logic [4:0]         rdIdx;
    logic               lastNonce;

    sha256_round u_round (
        .hash_i (hash_q),
        .w_i    (w_q),
        .t_i    (rnd_q),
        .hash_o (rndHash),
        .w_o    (rndW)
    );

    // During READ the data arriving now belongs to the address issued one
    // cycle earlier, hence the minus one.
    assign rdIdx     = rnd_q[4:0] - 5'd1;
    assign lastNonce = (idx_q == cnt_q - CNT_W'(1));

    assign mem_clk        = clk;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign done           = done_q;
    assign found          = found_q;
    assign found_nonce    = fnonce_q;

    // Next-state logic for the whole job sequencer. The same round instance
    // serves BLK1/BLK2/BLK3; the LD/FIN states set up the working variables
    // and message window around each 64-round pass. Every memory output is
    // computed here and registered, so read data never reaches the memory
    // pins combinationally.
    always_comb begin
        state_d  = state_q;
        hash_d   = hash_q;
        mid_d    = mid_q;
        w_d      = w_q;
        held_d   = held_q;
        rnd_d    = rnd_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        nonce_d  = nonce_q;
        h0_d     = h0_q;
        tgt_d    = tgt_q;
        mode_d   = mode_q;
        out_d    = out_q;
        done_d   = done_q;
        found_d  = found_q;
        fnonce_d = fnonce_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    out_d   = output_addr;
                    cnt_d   = nonce_count;
                    tgt_d   = target;
                    nonce_d = nonce_start;
                    idx_d   = '0;
                    rnd_d   = '0;
                    done_d  = 1'b0;
                    found_d = 1'b0;
                    if (nonce_count == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = message_addr;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (rnd_q != 6'd0) begin
                    if (rdIdx < 5'd16) begin
                        w_d[rdIdx[3:0]] = mem_read_data;
                    end else begin
                        held_d[rdIdx[1:0]] = mem_read_data;
                    end
                end
                if (rnd_q < 6'd18) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                if (rnd_q == 6'd19) begin
                    rnd_d   = '0;
                    hash_d  = IV;
                    state_d = BLK1;
                end else begin
                    rnd_d = rnd_q + 6'd1;
                end
            end
            BLK1, BLK2, BLK3: begin
                hash_d = rndHash;
                w_d    = rndW;
                rnd_d  = rnd_q + 6'd1;
                if (rnd_q == 6'd63) begin
                    state_d = (state_q == BLK1) ? FIN1 :
                              (state_q == BLK2) ? FIN2 : FIN3;
                end
            end
            FIN1: begin
                for (int i = 0; i < 8; i++) begin
                    mid_d[i] = IV[i] + hash_q[i];
                end
                state_d = LD2;
            end
            LD2: begin
                hash_d    = mid_q;
                w_d       = '0;
                w_d[0]    = held_q[0];
                w_d[1]    = held_q[1];
                w_d[2]    = held_q[2];
                w_d[3]    = nonce_q;
                w_d[4]    = PAD_WORD;
                w_d[15]   = LEN_BLK2;
                state_d   = BLK2;
            end
            FIN2: begin
                // The first digest becomes the second hash's message.
                for (int i = 0; i < 8; i++) begin
                    w_d[i] = mid_q[i] + hash_q[i];
                end
                w_d[8]    = PAD_WORD;
                w_d[14:9] = '0;
                w_d[15]   = LEN_BLK3;
                state_d   = LD3;
            end
            LD3: begin
                hash_d  = IV;
                state_d = BLK3;
            end
            FIN3: begin
                h0_d    = IV[0] + hash_q[0];
                state_d = CHK;
            end
            CHK: begin
                if (!mode_q) begin
                    we_d    = 1'b1;
                    addr_d  = out_q + ADDR_W'(idx_q);
                    wdata_d = h0_q;
                end else if (h0_q < tgt_q) begin
                    we_d     = 1'b1;
                    addr_d   = out_q;
                    wdata_d  = nonce_q;
                    fnonce_d = nonce_q;
                end else if (lastNonce) begin
                    we_d    = 1'b1;
                    addr_d  = out_q;
                    wdata_d = NO_HIT;
                end

                if (mode_q && (h0_q < tgt_q)) begin
                    state_d = WR2;
                end else if (lastNonce) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    nonce_d = nonce_q + 32'd1;
                    state_d = LD2;
                end
            end
            WR2: begin
                we_d    = 1'b1;
                addr_d  = out_q + ADDR_W'(1);
                wdata_d = h0_q;
                found_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register bank. Reset aborts any job at once and clears the
    // write strobe so nothing more reaches memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            hash_q   <= '0;
            mid_q    <= '0;
            w_q      <= '0;
            held_q   <= '0;
            rnd_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            nonce_q  <= '0;
            h0_q     <= '0;
            tgt_q    <= '0;
            mode_q   <= 1'b0;
            out_q    <= '0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            fnonce_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            hash_q   <= hash_d;
            mid_q    <= mid_d;
            w_q      <= w_d;
            held_q   <= held_d;
            rnd_q    <= rnd_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            nonce_q  <= nonce_d;
            h0_q     <= h0_d;
            tgt_q    <= tgt_d;
            mode_q   <= mode_d;
            out_q    <= out_d;
            done_q   <= done_d;
            found_q  <= found_d;
            fnonce_q <= fnonce_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_bitcoin_miner.sv
// tb_bitcoin_miner
// Self-checking bench for bitcoin_miner: a textbook SHA-256 model
// (full 64-word expansion on 512-bit vectors) predicts every memory write,
// the done cycle and the found flags for each job; one compare process
// checks the DUT against these predictions on every cycle.
module tb_bitcoin_miner;
    import bitcoin_pkg::K;

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic [31:0] nonce_start;
    logic [15:0] nonce_count;
    logic [31:0] target;
    logic        done;
    logic        found;
    logic [31:0] found_nonce;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [65536];
    logic [31:0] hdr [19];
    logic [47:0] expQ [$];
    logic [15:0] lastAddr;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          jobActive = 1'b0;
    int          expDoneCyc = 0;
    logic        expFound = 1'b0;
    logic [31:0] expFnonce = '0;

    bitcoin_miner #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .mode           (mode),
        .message_addr   (message_addr),
        .output_addr    (output_addr),
        .nonce_start    (nonce_start),
        .nonce_count    (nonce_count),
        .target         (target),
        .done           (done),
        .found          (found),
        .found_nonce    (found_nonce),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Word memory with one cycle of read latency, plus the cycle counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
    end

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256 compression of one 512-bit block.
    function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, t1, t2, ch, maj;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = st[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            s1  = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
            ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
            t1  = v[7] + s1 + ch + K[t] + w[t];
            s0  = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
            maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t2  = s0 + maj;
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = st[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    // Final h0 of the double hash for one nonce, given the header midstate.
    function automatic logic [31:0] h0For(input logic [255:0] mid, input logic [31:0] n);
        logic [255:0] d1, d2;
        d1 = compress(mid, {hdr[16], hdr[17], hdr[18], n, 32'h8000_0000, 320'd0, 32'd640});
        d2 = compress(IV256, {d1, 32'h8000_0000, 192'd0, 32'd256});
        return d2[255:224];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_found", {31'b0, found}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_found_nonce", found_nonce, 32'd0);
        checkOutput("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        checkOutput("rst_mem_wdata", mem_write_data, 32'd0);
    endtask

    task automatic pushWrite(input logic [15:0] a, input logic [31:0] d);
        expQ.push_back({a, d});
        lastAddr = a;
    endtask

    // Compare process: every write against the predicted sequence, done
    // against the predicted completion cycle, and the found status once done.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_we) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_write addr=%h data=%h required=no_write", mem_addr, mem_write_data);
                end else begin
                    logic [47:0] e;
                    e = expQ.pop_front();
                    checkOutput("write_addr", {16'b0, mem_addr}, {16'b0, e[47:32]});
                    checkOutput("write_data", mem_write_data, e[31:0]);
                end
            end
            if (jobActive) begin
                checkOutput("done", {31'b0, done}, {31'b0, (cyc >= expDoneCyc)});
                if (done) begin
                    checkOutput("found", {31'b0, found}, {31'b0, expFound});
                    if (expFound) checkOutput("found_nonce", found_nonce, expFnonce);
                end
            end
        end
    end

    // Runs one job: predicts its writes and timing, starts it, and either
    // lets it complete or aborts it with reset after abortAt cycles. With
    // busyPoke a conflicting start is pulsed while the job is running.
    task automatic applyStimulus(input logic m, input logic [15:0] maddr, input logic [15:0] oaddr,
                                 input logic [31:0] nstart, input logic [15:0] ncount,
                                 input logic [31:0] tgt, input int abortAt, input bit busyPoke);
        logic [511:0] b1;
        logic [255:0] mid;
        logic [31:0]  n, h;
        int           doneOff, s;
        bit           hit;
        for (int k = 0; k < 19; k++) begin
            hdr[k] = $urandom;
            mem[maddr + 16'(k)] = hdr[k];
        end
        for (int k = 0; k < 16; k++) b1[511 - 32*k -: 32] = hdr[k];
        mid = compress(IV256, b1);
        expFound = 1'b0;
        expFnonce = '0;
        if (ncount == 0) begin
            doneOff = 2;
        end else if (!m) begin
            for (int i = 0; i < int'(ncount); i++) begin
                n = nstart + 32'(i);
                pushWrite(oaddr + 16'(i), h0For(mid, n));
            end
            doneOff = 87 + 133 * int'(ncount);
        end else begin
            hit = 1'b0;
            doneOff = 87 + 133 * int'(ncount);
            for (int i = 0; i < int'(ncount) && !hit; i++) begin
                n = nstart + 32'(i);
                h = h0For(mid, n);
                if (h < tgt) begin
                    hit = 1'b1;
                    pushWrite(oaddr, n);
                    pushWrite(oaddr + 16'd1, h);
                    expFound = 1'b1;
                    expFnonce = n;
                    doneOff = 87 + 133 * (i + 1) + 1;
                end
            end
            if (!hit) pushWrite(oaddr, 32'hffff_ffff);
        end

        @(posedge clk); #1;
        mode = m; message_addr = maddr; output_addr = oaddr;
        nonce_start = nstart; nonce_count = ncount; target = tgt;
        start = 1'b1;
        s = cyc;
        expDoneCyc = s + doneOff;
        @(posedge clk); #1;
        start = 1'b0;
        jobActive = 1'b1;

        while (cyc < s + doneOff + 3) begin
            @(posedge clk); #1;
            if (busyPoke && cyc == s + 60) begin
                start = 1'b1; nonce_count = 16'd0; mode = ~m; output_addr = ~oaddr;
            end
            if (busyPoke && cyc == s + 61) start = 1'b0;
            if (abortAt > 0 && cyc == s + abortAt) begin
                jobActive = 1'b0;
                expQ.delete();
                lastAddr = '0;
                reset_n = 1'b0;
                @(negedge clk);
                checkReset();
                @(posedge clk); #1;
                @(posedge clk); #1;
                reset_n = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                checkReset();
                return;
            end
        end
        jobActive = 1'b0;
        checkOutput("writes_pending", expQ.size(), 32'd0);
        if (ncount == 0) checkOutput("idle_mem_addr", {16'b0, mem_addr}, {16'b0, lastAddr});
    endtask

    initial begin
        logic [255:0] d;
        logic [511:0] blk;
        reset_n = 1'b0;
        start = 1'b0; mode = 1'b0; message_addr = '0; output_addr = '0;
        nonce_start = '0; nonce_count = '0; target = '0;
        lastAddr = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkReset();

        // Pin the reference model with published SHA-256 digests.
        d = compress(IV256, {32'h61626380, 448'd0, 32'd24});
        checkOutput("model_abc_h0", d[255:224], 32'hba7816bf);
        checkOutput("model_abc_h7", d[31:0], 32'hf20015ad);
        for (int k = 0; k < 14; k++)
            blk[511 - 32*k -: 32] = {8'(97 + k), 8'(98 + k), 8'(99 + k), 8'(100 + k)};
        blk[63:0] = {32'h8000_0000, 32'd0};
        d = compress(IV256, blk);
        d = compress(d, {480'd0, 32'h1c0});
        checkOutput("model_2blk_h0", d[255:224], 32'h248d6a61);
        checkOutput("model_2blk_h7", d[31:0], 32'h19db06c1);

        // Dump sweep of 16 nonces: done lands 2215 cycles after start.
        applyStimulus(1'b0, 16'h0100, 16'h2000, 32'd0, 16'd16, 32'd0, 0, 1'b0);
        // Empty range: done two cycles after start, no memory activity.
        applyStimulus(1'b0, 16'h0300, 16'h3000, 32'd5, 16'd0, 32'd0, 0, 1'b0);
        // Search that must hit on the first nonce.
        applyStimulus(1'b1, 16'h0400, 16'h4000, $urandom, 16'd5, 32'hffff_ffff, 0, 1'b0);
        // Search that can never hit.
        applyStimulus(1'b1, 16'h0500, 16'h5000, $urandom, 16'd4, 32'd0, 0, 1'b0);
        // Nonce and address wrap-around.
        applyStimulus(1'b0, 16'hfff8, 16'hffff, 32'hffff_fffe, 16'd3, 32'd0, 0, 1'b0);
        // Reset in the middle of the second-block pass, then a clean job
        // with a conflicting start pulsed while busy.
        applyStimulus(1'b0, 16'h0600, 16'h6000, $urandom, 16'd4, 32'd0, 120, 1'b0);
        applyStimulus(1'b0, 16'h0700, 16'h7000, $urandom, 16'd2, 32'd0, 0, 1'b1);
        // Randomized jobs.
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom_range(16'h8000, 16'hfff0)),
                          $urandom, 16'($urandom_range(1, 4)), $urandom_range(0, 32'h6000_0000), 0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitcoin_miner.md
# bitcoin_miner

Parametrised double-SHA256 nonce sweeper, successor to the fixed 16-nonce hasher in the mining datapath. Reads a 19-word block header prefix from word memory, hashes the first 512-bit block once, then sweeps a run-time nonce range. It operates in one of two modes:
- **Dump mode:** writes `h0` of every double hash.
- **Search mode:** stops at the first hash whose `h0` is below a target, and reports it.

## Interface
Parameters:
- `ADDR_W`, default 16: memory address width.
- `CNT_W`, default 16: width of the nonce count.

Ports:
- `clk` in, 1: single clock. `mem_clk` equals `clk`.
- `reset_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: one-cycle request; accepted only in `IDLE`.
- `mode` in, 1: 0 = dump, 1 = search. Sampled at start.
- `message_addr`, `output_addr` in, `ADDR_W`: base addresses. Sampled at start.
- `nonce_start` in, 32: first nonce. Sampled at start.
- `nonce_count` in, `CNT_W`: number of nonces. Sampled at start.
- `target` in, 32: search threshold on final `h0`. Sampled at start.
- `done` out, 1: high from job completion until the next accepted start.
- `found` out, 1: search hit. Valid while `done` is high.
- `found_nonce` out, 32: winning nonce. Valid while `found` is high.
- `mem_clk` out, 1: equal to `clk`.
- `mem_we` out, 1: write strobe.
- `mem_addr` out, `ADDR_W`: memory address.
- `mem_write_data` out, 32: write data.
- `mem_read_data` in, 32: read data, 1-cycle latency after `mem_addr`.

Reset values: `done`, `found`, `mem_we` = 0; `found_nonce`, `mem_addr`, `mem_write_data` = 0; state = `IDLE`.

## Operation
- States: `IDLE`, `READ`, `BLK1`, `FIN1`, `LD2`, `BLK2`, `FIN2`, `LD3`, `BLK3`, `FIN3`, `CHK`, `WR2`, `DONE`.
- **Start:** `IDLE` + `start` latches all inputs and clears `done`/`found`.
  - If `nonce_count == 0`: go to `DONE`; no memory access occurs.
  - Otherwise: go to `READ`.
- **`READ`:** 20 cycles. Reads words `message_addr+0..18`. Words 0..15 go into the W buffer; words 16..18 are held.
- **`BLK1`:** 64 rounds from the SHA-256 IV, using a 16-entry rolling message schedule. `FIN1` adds the IV and stores the midstate.
- **Per nonce `n = nonce_start + i`:**
  - `LD2` loads a..h from the midstate.
  - `BLK2` runs over: held words 16..18, `n`, 0x80000000, ten zero words, 640.
  - `FIN2` adds the midstate.
  - `LD3` loads the IV.
  - `BLK3` runs over: digest words 0..7, 0x80000000, six zero words, 256.
  - `FIN3` adds the IV.
  - `CHK` evaluates the result.
- **`CHK`, dump mode:** writes `h0` to `output_addr+i`. Then continues to the next nonce, or goes to `DONE` after `i = nonce_count-1`.
- **`CHK`, search mode, hit:** if `h0 < target` (unsigned), writes `n` to `output_addr` and sets `found_nonce = n`. `WR2` then writes `h0` to `output_addr+1`, sets `found = 1`, and goes to `DONE`.
- **`CHK`, search mode, miss:** continues to the next nonce. If the range is exhausted, writes 0xFFFFFFFF to `output_addr` and goes to `DONE` with `found = 0`.
- **`DONE`:** drives `done = 1` and returns to `IDLE` in the next cycle. `done` stays high in `IDLE`.
- **Arithmetic:** all additions are mod 2^32. The nonce wraps mod 2^32. Addresses wrap mod 2^`ADDR_W`.
- `start` asserted while busy is ignored.
- Reset asserted mid-job aborts immediately. No further writes occur after reset asserts.

## Timing
- `mem_we` is high for exactly one cycle per write, in the cycle following `CHK`/`WR2`.
- `mem_addr` is a registered output.
- Latency from start accepted to the first nonce's `CHK`: 20 + 64 + 1 + 133 = 218 cycles.
- Each additional nonce adds 133 cycles.
- In dump mode, `done` rises N×133 + 87 cycles after start is accepted.
- A search hit adds 1 cycle (`WR2`) before `DONE`.
- Round throughput: one `sha256_op` per cycle. No combinational path exists from memory read data to memory outputs.

## Structure
- Package `bitcoin_pkg` holds:
  - K[0:63], the IV constants, and the padding words.
  - Functions `rightrotate`, `sha256_op`, and the schedule word.
  - State enum type.
- One sub-module: `sha256_round`, a combinational single round with schedule shift (a..h, w[15:0], t in; next a..h, w out). It is instantiated once and reused across `BLK1`/`BLK2`/`BLK3`.

## Test plan
- **Dump mode, standard 19-word vector:** `nonce_start=0`, `nonce_count=16`. Expect 16 writes at `output_addr..+15` matching the golden model, `done` at cycle 2215, and `found = 0`.
- **`nonce_count = 0`:** expect `done` 2 cycles after start, zero reads, and zero writes.
- **Search, `target = 0xFFFFFFFF`:** expect a hit on the first nonce, with `found = 1`, `found_nonce = nonce_start`, and two writes (nonce, `h0`).
- **Search, `target = 0`:** `nonce_count=4` gives no hit. Expect a single write of 0xFFFFFFFF and `found = 0`.
- **Wrap-around:** `nonce_start = 0xFFFFFFFE`, `nonce_count = 3`, `output_addr = 0xFFFF`. Expect nonces FFFFFFFE, FFFFFFFF, 0 and addresses FFFF, 0000, 0001.
- **Abort and busy handling:** `reset_n` pulsed low mid-`BLK2` returns all outputs to reset values with no write. A subsequent start completes normally. A second `start` during a job is ignored.
